// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data memory between the CPU M-stage port and an external loader port.
// Optional misaligned-access trap enabled by defining DMEM_ARB_MISALIGN_TRAP_EN.
module dmem_port_arbiter #(
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic [2:0]  cpu_funct3,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   output logic        cpu_misalign,
   input  logic        ext_req,
   input  logic        ext_we,
   input  logic [31:0] ext_addr,
   input  logic [31:0] ext_wdata,
   input  logic [3:0]  ext_wstrb,
   output logic        ext_gnt,
   output logic        ext_done,
   output logic [31:0] ext_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_e;
   typedef enum logic {OWN_CPU = 1'b0, OWN_EXT = 1'b1} owner_e;

   state_e           state_q, state_d;
   owner_e           owner_q, owner_d;
   owner_e           last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [3:0]       wstrb_q, wstrb_d;
   logic             we_q, we_d;
   logic [2:0]       f3_q, f3_d;
   logic             trap_q, trap_d;
   logic [31:0]      rdata_q, rdata_d;

   logic             grant_ext_c;
   logic [3:0]       cpu_strb_c;
   logic [31:0]      cpu_wrep_c;
   logic             misalign_c;
   logic [7:0]       byte_c;
   logic [15:0]      half_c;
   logic [31:0]      load_c;

   // Ext wins only when CPU is idle or CPU had the previous grant
   assign grant_ext_c = ext_req && (!cpu_req || last_q == OWN_CPU);

`ifdef DMEM_ARB_MISALIGN_TRAP_EN
   assign misalign_c = ((cpu_funct3[1:0] == 2'b01) && cpu_addr[0]) ||
                       ((cpu_funct3[1:0] == 2'b10) && (cpu_addr[1:0] != 2'b00));
`else
   assign misalign_c = 1'b0;
`endif

   // Store lane strobes and data replication
   always_comb begin
      cpu_strb_c = 4'b1111;
      cpu_wrep_c = cpu_wdata;
      case (cpu_funct3[1:0])
         2'b00: begin
            cpu_strb_c = 4'b0001 << cpu_addr[1:0];
            cpu_wrep_c = {4{cpu_wdata[7:0]}};
         end
         2'b01: begin
            cpu_strb_c = 4'b0011 << {cpu_addr[1], 1'b0};
            cpu_wrep_c = {2{cpu_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Load lane select and extension
   always_comb begin
      byte_c = rdata_q[{addr_q[1:0], 3'b000} +: 8];
      half_c = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
      case (f3_q[1:0])
         2'b00:   load_c = f3_q[2] ? {24'b0, byte_c} : {{24{byte_c[7]}}, byte_c};
         2'b01:   load_c = f3_q[2] ? {16'b0, half_c} : {{16{half_c[15]}}, half_c};
         default: load_c = rdata_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         owner_q <= OWN_CPU;
         last_q  <= OWN_EXT;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         we_q    <= 1'b0;
         f3_q    <= '0;
         trap_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         trap_q  <= trap_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_d       = last_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      we_d         = we_q;
      f3_d         = f3_q;
      trap_d       = trap_q;
      rdata_d      = rdata_q;
      ext_gnt      = 1'b0;
      cpu_misalign = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (grant_ext_c) begin
               ext_gnt = 1'b1;
               owner_d = OWN_EXT;
               addr_d  = ext_addr;
               wdata_d = ext_wdata;
               wstrb_d = ext_wstrb;
               we_d    = ext_we;
               f3_d    = 3'b010;
               trap_d  = 1'b0;
               cnt_d   = '0;
               state_d = ST_ACCESS;
            end else if (cpu_req) begin
               cpu_misalign = misalign_c;
               owner_d = OWN_CPU;
               addr_d  = cpu_addr;
               wdata_d = cpu_wrep_c;
               wstrb_d = cpu_strb_c;
               we_d    = cpu_we;
               f3_d    = cpu_funct3;
               trap_d  = misalign_c;
               cnt_d   = '0;
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               rdata_d = mem_rdata;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            last_d  = owner_q;
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign mem_en    = (state_q == ST_ACCESS) && !trap_q;
   assign mem_we    = mem_en && we_q;
   assign mem_wstrb = wstrb_q;
   assign mem_addr  = {addr_q[31:2], 2'b00};
   assign mem_wdata = wdata_q;

   assign ext_done  = (state_q == ST_DONE) && (owner_q == OWN_EXT);
   assign ext_rdata = rdata_q;
   assign cpu_rdata = ((state_q == ST_DONE) && (owner_q == OWN_CPU) && !trap_q) ? load_c : '0;
   assign cpu_stall = cpu_req && !((state_q == ST_DONE) && (owner_q == OWN_CPU));

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with WAIT_CYCLES=2 and a behavioural byte-strobed memory.
module tb_dmem_port_arbiter;
   localparam int unsigned WAIT = 2;
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk, reset;
   logic        cpu_req, cpu_we;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic [2:0]  cpu_funct3;
   logic        cpu_stall, cpu_misalign;
   logic        ext_req, ext_we, ext_gnt, ext_done;
   logic [31:0] ext_addr, ext_wdata, ext_rdata;
   logic [3:0]  ext_wstrb;
   logic        mem_en, mem_we;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_clear;

   int n_cmp = 0;
   int n_err = 0;

   dmem_port_arbiter #(.WAIT_CYCLES(WAIT)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_funct3(cpu_funct3), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .cpu_misalign(cpu_misalign),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_wstrb(ext_wstrb), .ext_gnt(ext_gnt), .ext_done(ext_done), .ext_rdata(ext_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 64-word memory, combinational read, strobed write on the clock edge
   logic [31:0] mem [64];
   assign mem_rdata = mem[mem_addr[7:2]];
   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      end else if (mem_en && mem_we) begin
         for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  f3;
      logic [3:0]  strb;
      logic [31:0] maddr;
      logic [31:0] mwdata;
      logic        chk_rd;
      logic [31:0] rd;
      int          en;
      logic        mis;
   } vec_t;

   function automatic vec_t mk(logic we, logic [31:0] a, logic [31:0] wd, logic [2:0] f3,
                               logic [3:0] st, logic [31:0] ma, logic [31:0] mwd,
                               logic chk, logic [31:0] rd, int en, logic mis);
      vec_t v;
      v.we = we; v.addr = a; v.wdata = wd; v.f3 = f3; v.strb = st; v.maddr = ma;
      v.mwdata = mwd; v.chk_rd = chk; v.rd = rd; v.en = en; v.mis = mis;
      return v;
   endfunction

   // One CPU transaction; entered and left just after a rising edge with the FSM idle
   task automatic cpu_access(input vec_t v, input int idx);
      int stall_n, en_n, we_n, mis_n;
      logic done;
      logic [3:0]  s;
      logic [31:0] a, d;
      stall_n = 0; en_n = 0; we_n = 0; mis_n = 0; done = 1'b0; s = '0; a = '0; d = '0;
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata; cpu_funct3 = v.f3;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         if (cpu_misalign) mis_n++;
         if (mem_en) begin en_n++; s = mem_wstrb; a = mem_addr; d = mem_wdata; end
         if (mem_we) we_n++;
         if (cpu_stall) stall_n++;
         else begin
            done = 1'b1;
            if (v.chk_rd) check($sformatf("v%0d cpu_rdata", idx), cpu_rdata, v.rd);
         end
         @(posedge clk); #1;
      end
      cpu_req = 1'b0; cpu_we = 1'b0;
      check($sformatf("v%0d done", idx), 32'(done), 32'd1);
      check($sformatf("v%0d stall_cycles", idx), 32'(stall_n), 32'(WAIT + 1));
      check($sformatf("v%0d en_cycles", idx), 32'(en_n), 32'(v.en));
      check($sformatf("v%0d we_cycles", idx), 32'(we_n), v.we ? 32'(v.en) : 32'd0);
      check($sformatf("v%0d misalign", idx), 32'(mis_n), 32'(v.mis));
      if (en_n > 0) check($sformatf("v%0d mem_addr", idx), a, v.maddr);
      if (v.we && en_n > 0) begin
         check($sformatf("v%0d mem_wstrb", idx), 32'(s), 32'(v.strb));
         check($sformatf("v%0d mem_wdata", idx), d, v.mwdata);
      end
   endtask

   // One uncontended external transaction
   task automatic ext_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [3:0] st, input logic [31:0] exp_rd, input string nm);
      int g, dn;
      g = -1; dn = -1;
      ext_req = 1'b1; ext_we = we; ext_addr = addr; ext_wdata = wd; ext_wstrb = st;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (ext_gnt && g < 0) g = c;
         if (ext_done && dn < 0) begin
            dn = c;
            if (!we) check({nm, " ext_rdata"}, ext_rdata, exp_rd);
         end
         @(posedge clk); #1;
         if (g >= 0) ext_req = 1'b0;
      end
      ext_req = 1'b0;
      check({nm, " gnt_cycle"}, 32'(g), 32'd0);
      check({nm, " done_cycle"}, 32'(dn), 32'(WAIT + 1));
   endtask

   vec_t vq[$];

   initial begin
      int gnt_c, done_c, cd1, cd2, gnt_n, seen;
      logic [31:0] rd1, rd2;

      vq.push_back(mk(1, 32'h10, 32'hDEADBEEF, 3'b010, 4'b1111, 32'h10, 32'hDEADBEEF, 0, 0, 2, 0));
      vq.push_back(mk(1, 32'h13, 32'h000000A5, 3'b000, 4'b1000, 32'h10, 32'hA5A5A5A5, 0, 0, 2, 0));
      vq.push_back(mk(0, 32'h13, 0, 3'b000, 0, 32'h10, 0, 1, 32'hFFFFFFA5, 2, 0));
      vq.push_back(mk(0, 32'h13, 0, 3'b100, 0, 32'h10, 0, 1, 32'h000000A5, 2, 0));
      vq.push_back(mk(0, 32'h12, 0, 3'b001, 0, 32'h10, 0, 1, 32'hFFFFA5AD, 2, 0));
      vq.push_back(mk(0, 32'h12, 0, 3'b101, 0, 32'h10, 0, 1, 32'h0000A5AD, 2, 0));
      vq.push_back(mk(0, 32'h10, 0, 3'b001, 0, 32'h10, 0, 1, 32'hFFFFBEEF, 2, 0));
      vq.push_back(mk(0, 32'h11, 0, 3'b000, 0, 32'h10, 0, 1, 32'hFFFFFFBE, 2, 0));
      vq.push_back(mk(0, 32'h10, 0, 3'b010, 0, 32'h10, 0, 1, 32'hA5ADBEEF, 2, 0));
      vq.push_back(mk(0, 32'h22, 0, 3'b001, 0, 32'h20, 0, 1, 32'h00001234, 2, 0));
      vq.push_back(mk(1, 32'h16, 32'hABCD1234, 3'b001, 4'b1100, 32'h14, 32'h12341234, 0, 0, 2, 0));
      vq.push_back(mk(0, 32'h16, 0, 3'b101, 0, 32'h14, 0, 1, 32'h00001234, 2, 0));
      vq.push_back(mk(0, 32'h14, 0, 3'b001, 0, 32'h14, 0, 1, 32'h00000000, 2, 0));
      vq.push_back(mk(1, 32'h06, 32'hCAFEF00D, 3'b010, 4'b1111, 32'h04, 32'hCAFEF00D,
                      TRAP, 0, TRAP ? 0 : 2, TRAP));
      vq.push_back(mk(0, 32'h04, 0, 3'b010, 0, 32'h04, 0, 1, TRAP ? 32'h0 : 32'hCAFEF00D, 2, 0));
      vq.push_back(mk(0, 32'h13, 0, 3'b001, 0, 32'h10, 0, 1, TRAP ? 32'h0 : 32'hFFFFA5AD,
                      TRAP ? 0 : 2, TRAP));

      reset = 1'b0; mem_clear = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_funct3 = '0;
      ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0; ext_wstrb = '0;
      @(posedge clk); @(negedge clk);
      check("rst cpu_stall_follows_req", 32'(cpu_stall), 32'd1);
      check("rst mem_en", 32'(mem_en), 32'd0);
      check("rst mem_we", 32'(mem_we), 32'd0);
      check("rst mem_wstrb", 32'(mem_wstrb), 32'd0);
      check("rst mem_addr", mem_addr, 32'd0);
      check("rst ext_gnt", 32'(ext_gnt), 32'd0);
      check("rst ext_done", 32'(ext_done), 32'd0);
      check("rst cpu_rdata", cpu_rdata, 32'd0);
      check("rst cpu_misalign", 32'(cpu_misalign), 32'd0);
      cpu_req = 1'b0;
      #1 check("rst cpu_stall_low", 32'(cpu_stall), 32'd0);
      @(posedge clk); #1;
      mem_clear = 1'b0; reset = 1'b1;

      // Simultaneous requests after reset: CPU first, then ext wins the next tie
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20; cpu_funct3 = 3'b010;
      ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h20; ext_wdata = 32'h12345678; ext_wstrb = 4'hF;
      gnt_c = -1; done_c = -1; cd1 = -1; cd2 = -1; gnt_n = 0; rd1 = '1; rd2 = '1;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         if (ext_gnt) begin gnt_n++; if (gnt_c < 0) gnt_c = c; end
         if (ext_done && done_c < 0) done_c = c;
         if (cpu_req && !cpu_stall) begin
            if (cd1 < 0) begin cd1 = c; rd1 = cpu_rdata; end
            else begin cd2 = c; rd2 = cpu_rdata; end
         end
         @(posedge clk); #1;
         if (gnt_c == c) ext_req = 1'b0;
         if (cd2 == c) cpu_req = 1'b0;
      end
      cpu_req = 1'b0; ext_req = 1'b0;
      check("tie cpu_done1_cycle", 32'(cd1), 32'(WAIT + 1));
      check("tie cpu_rdata1", rd1, 32'h0);
      check("tie ext_gnt_cycle", 32'(gnt_c), 32'(WAIT + 2));
      check("tie ext_gnt_pulses", 32'(gnt_n), 32'd1);
      check("tie ext_done_cycle", 32'(done_c), 32'(2 * WAIT + 3));
      check("tie cpu_done2_cycle", 32'(cd2), 32'(3 * WAIT + 5));
      check("tie cpu_rdata2", rd2, 32'h12345678);

      foreach (vq[i]) cpu_access(vq[i], i);

      // Reset during an ext access aborts it
      ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h20;
      @(negedge clk);
      check("abort gnt", 32'(ext_gnt), 32'd1);
      @(posedge clk); #1 ext_req = 1'b0;
      @(negedge clk);
      check("abort mem_en_before", 32'(mem_en), 32'd1);
      #2 reset = 1'b0;
      #1 check("abort mem_en_async", 32'(mem_en), 32'd0);
      check("abort mem_we_async", 32'(mem_we), 32'd0);
      @(posedge clk); @(posedge clk); #1 reset = 1'b1;
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (ext_done) seen++;
      end
      @(posedge clk); #1;
      check("abort no_ext_done", 32'(seen), 32'd0);
      ext_access(1'b0, 32'h23, 32'h0, 4'h0, 32'h12345678, "recover");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
